// File: rtl/operand_loader_if.sv
// Bus bundle between the operand loader, the host that streams operand words
// and the normalising-multiplier controller that reads them back.
interface operand_loader_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              start;
    logic              done;
    logic              busy;
    logic [AW:0]       wr_count;
`ifdef OPERAND_ZERO_CHECK_EN
    logic              zero_err;
`endif

    // slave is the loader itself; master is the host/controller side
    modport slave (
        input  in_valid, in_data, rd_addr, done,
        output in_ready, rd_data, start, busy, wr_count
`ifdef OPERAND_ZERO_CHECK_EN
        , output zero_err
`endif
    );

    modport master (
        output in_valid, in_data, rd_addr, done,
        input  in_ready, rd_data, start, busy, wr_count
`ifdef OPERAND_ZERO_CHECK_EN
        , input zero_err
`endif
    );
endinterface

// File: rtl/operand_loader.sv
// Operand loader: buffers DEPTH host words (A/B pairs), launches the multiplier
// controller once full and waits for done. Optional zero-operand flag: OPERAND_ZERO_CHECK_EN.
module operand_loader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    operand_loader_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {FILL, LAUNCH, RELEASE, WAIT} state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       wr_count;
    logic              accept;
    logic              last_word;
    logic              batch_done;

    assign accept     = bus.in_valid && (state == FILL);
    assign last_word  = (wr_ptr == AW'(DEPTH - 1));
    assign batch_done = (state == WAIT) && bus.done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL:    if (accept && last_word) next_state = LAUNCH;
            LAUNCH:  next_state = RELEASE;
            RELEASE: next_state = WAIT;
            WAIT:    if (bus.done) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        bus.start    = 1'b0;
        bus.busy     = 1'b1;
        case (state)
            FILL: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            LAUNCH:  bus.start = 1'b1;
            default: ;
        endcase
    end

    // wr_ptr parks at DEPTH-1 after the last word; only the return to FILL rewinds it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            wr_count <= '0;
        end else if (batch_done) begin
            wr_ptr   <= '0;
            wr_count <= '0;
        end else if (accept) begin
            wr_count <= wr_count + 1'b1;
            if (!last_word) wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Storage is deliberately not reset so earlier batches stay readable
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= bus.in_data;
    end

    assign bus.rd_data  = mem[bus.rd_addr];
    assign bus.wr_count = wr_count;

`ifdef OPERAND_ZERO_CHECK_EN
    logic zero_err;

    // A zero operand has no leading one, so the normaliser cannot handle it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              zero_err <= 1'b0;
        else if (batch_done)                  zero_err <= 1'b0;
        else if (accept && bus.in_data == '0) zero_err <= 1'b1;
    end

    assign bus.zero_err = zero_err;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed batches with random data
// and gaps, compared against a word-count level reference model.
module tb_operand_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: words held in the current batch, edges since it filled
    logic [15:0] ref_mem [16];
    int          ref_count  = 0;
    int          since_full = 0;
    logic        ref_zero   = 1'b0;

    operand_loader_if #(.DATA_W(16), .DEPTH(16)) bus ();

    operand_loader #(.DATA_W(16), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Check the current cycle against the model, then drive the next edge's inputs
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic dn);
        @(negedge clk);
        checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, ref_count < 16});
        checkOutput("busy",     {31'd0, bus.busy},     {31'd0, ref_count == 16});
        checkOutput("start",    {31'd0, bus.start},    {31'd0, ref_count == 16 && since_full == 1});
        checkOutput("wr_count", {27'd0, bus.wr_count}, ref_count);
`ifdef OPERAND_ZERO_CHECK_EN
        checkOutput("zero_err", {31'd0, bus.zero_err}, {31'd0, ref_zero});
`endif
        bus.in_valid = v;
        bus.in_data  = d;
        bus.done     = dn;
        if (rst) begin
            ref_count  = 0;
            since_full = 0;
            ref_zero   = 1'b0;
        end else if (ref_count == 16) begin
            // start high one cycle, one release cycle, then waiting for done
            if (dn && since_full >= 3) begin
                ref_count  = 0;
                since_full = 0;
                ref_zero   = 1'b0;
            end else begin
                since_full++;
            end
        end else if (v) begin
            ref_mem[ref_count] = d;
            if (d == 16'h0000) ref_zero = 1'b1;
            ref_count++;
            if (ref_count == 16) since_full = 1;
        end
    endtask

    task automatic readCheck(input int addr);
        bus.rd_addr = addr[3:0];
        #1;
        checkOutput($sformatf("rd_data[%0d]", addr), {16'd0, bus.rd_data}, {16'd0, ref_mem[addr]});
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.done     = 1'b0;
        bus.rd_addr  = '0;

        // Reset values
        repeat (2) applyStimulus(1'b0, 16'h0000, 1'b0);
        rst = 1'b0;

        // Normal fill with 0x0101..0x0110, valid held high
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'h0101 + 16'(i), 1'b0);

        // Backpressure: launch, release, then 20 cycles of held 0xFFFF
        for (int i = 0; i < 22; i++) applyStimulus(1'b1, 16'hFFFF, 1'b0);
        bus.rd_addr = 4'd5;
        #1;
        checkOutput("rd5_const", {16'd0, bus.rd_data}, 32'h0106);
        bus.rd_addr = 4'd0;
        #1;
        checkOutput("rd0_const", {16'd0, bus.rd_data}, 32'h0101);
        for (int a = 0; a < 16; a++) readCheck(a);

        // Done in WAIT returns to FILL
        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0);

        // First word goes to address 0; done pulses during FILL are ignored
        applyStimulus(1'b1, 16'($urandom), 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        readCheck(0);
        readCheck(1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1);

        // Gapped input: valid toggles each cycle, random stray done pulses
        begin
            int budget = 200;
            logic v = 1'b0;
            while (ref_count < 16 && budget > 0) begin
                v = ~v;
                applyStimulus(v, 16'($urandom), ($urandom_range(0, 5) == 0));
                budget--;
            end
            applyStimulus(1'b0, 16'h0000, 1'b0);
            checkOutput("fill_timeout", {27'd0, bus.wr_count}, 32'd16);
        end
        repeat (4) applyStimulus(1'b0, 16'h0000, 1'b0);
        for (int a = 0; a < 16; a++) readCheck(a);

        // Asynchronous reset mid-batch (in WAIT)
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_busy",     {31'd0, bus.busy},     32'd0);
        checkOutput("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("arst_wr_count", {27'd0, bus.wr_count}, 32'd0);
        checkOutput("arst_start",    {31'd0, bus.start},    32'd0);
        ref_count  = 0;
        since_full = 0;
        ref_zero   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        for (int a = 0; a < 16; a++) readCheck(a);

        // Batch with a zero operand as word 3, random valid gaps
        begin
            int budget = 300;
            int sent = 0;
            logic v;
            while (ref_count < 16 && budget > 0) begin
                v = ($urandom_range(0, 3) != 0);
                applyStimulus(v, (sent == 3) ? 16'h0000 : (16'($urandom) | 16'h0001), 1'b0);
                if (v) sent++;
                budget--;
            end
            applyStimulus(1'b0, 16'h0000, 1'b0);
            checkOutput("zero_fill_timeout", {27'd0, bus.wr_count}, 32'd16);
        end
        repeat (3) applyStimulus(1'b0, 16'h0000, 1'b0);
        for (int a = 0; a < 16; a++) readCheck(a);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        repeat (2) applyStimulus(1'b0, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
